rv_core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It fetches each instruction over a req/ack memory bus and decodes it into the fields and controls that drive the ALU and register-file datapath. It then sequences execute, memory and writeback, and maintains the PC. It sits above the combinational ALU and the register file and is the only master of the instruction/data memory port.

---
 rtl/rv_core_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_rv_core_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_core_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory and writeback
// over a single req/ack memory port, with PC and retired-instruction tracking.
module rv_core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] reg1_data,
    input  logic [31:0] reg2_data,
    input  logic [31:0] alu_result,
    input  logic        alu_branch,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] immediate,
    output logic        alu_source,
    output logic        reg_write_en,
    output logic [31:0] reg_write_data,
    output logic [31:0] pc,
    output logic        halt,
    output logic [31:0] retired
);

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic        fetch_busy;

    logic [31:0] dec_imm;
    logic        dec_legal;
    logic        dec_alu_src;

    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        fetch_active;
    logic [31:0] pc_plus4;
    logic [31:0] pc_offset;
    logic [31:0] data_addr;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] wb_pc;

    // Immediate selection and legality check on the raw instruction register.
    always_comb begin
        dec_imm     = '0;
        dec_legal   = 1'b0;
        dec_alu_src = 1'b0;
        case (ir[6:0])
            OP_ALU: begin
                dec_legal = 1'b1;
            end
            OP_ALUI: begin
                dec_legal   = 1'b1;
                dec_imm     = {{20{ir[31]}}, ir[31:20]};
                dec_alu_src = 1'b1;
            end
            OP_LOAD: begin
                dec_legal   = (ir[14:12] == 3'b010);
                dec_imm     = {{20{ir[31]}}, ir[31:20]};
                dec_alu_src = 1'b1;
            end
            OP_STORE: begin
                dec_legal   = (ir[14:12] == 3'b010);
                dec_imm     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                dec_alu_src = 1'b1;
            end
            OP_BRANCH: begin
                dec_legal = 1'b1;
                dec_imm   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_legal = 1'b1;
                dec_imm   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OP_JALR: begin
                dec_legal = 1'b1;
                dec_imm   = {{20{ir[31]}}, ir[31:20]};
            end
            OP_LUI: begin
                dec_legal   = 1'b1;
                dec_imm     = {12'b0, ir[31:12]};
                dec_alu_src = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        is_load       = (opcode == OP_LOAD);
        is_store      = (opcode == OP_STORE);
        is_branch     = (opcode == OP_BRANCH);
        is_jal        = (opcode == OP_JAL);
        is_jalr       = (opcode == OP_JALR);
        pc_plus4      = pc + 32'd4;
        pc_offset     = pc + immediate;
        data_addr     = reg1_data + immediate;
        branch_target = alu_branch ? pc_offset : pc_plus4;
        jalr_target   = {data_addr[31:1], 1'b0};
        wb_pc         = (is_jal || is_jalr) ? pc : pc_plus4;
        fetch_active  = (state == ST_FETCH) && (enable || fetch_busy);
    end

    // Gated by rst so an abandoned request drops the moment reset asserts.
    assign mem_req = rst && (fetch_active || (state == ST_MEM));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_FETCH;
            ir             <= '0;
            fetch_busy     <= 1'b0;
            pc             <= RESET_PC;
            mem_addr       <= RESET_PC;
            mem_we         <= 1'b0;
            mem_wdata      <= '0;
            opcode         <= '0;
            funct3         <= '0;
            funct7         <= '0;
            rd             <= '0;
            rs1            <= '0;
            rs2            <= '0;
            immediate      <= '0;
            alu_source     <= 1'b0;
            reg_write_en   <= 1'b0;
            reg_write_data <= '0;
            halt           <= 1'b0;
            retired        <= '0;
        end else begin
            reg_write_en <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (fetch_active) begin
                        if (mem_ack) begin
                            ir         <= mem_rdata;
                            fetch_busy <= 1'b0;
                            state      <= ST_DECODE;
                        end else begin
                            fetch_busy <= 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    opcode     <= ir[6:0];
                    funct3     <= ir[14:12];
                    funct7     <= ir[31:25];
                    rd         <= ir[11:7];
                    rs1        <= ir[19:15];
                    rs2        <= ir[24:20];
                    immediate  <= dec_imm;
                    alu_source <= dec_alu_src;
                    if (dec_legal) begin
                        state <= ST_EXECUTE;
                    end else begin
                        halt  <= 1'b1;
                        state <= ST_HALT;
                    end
                end
                ST_EXECUTE: begin
                    if (is_load || is_store) begin
                        if (data_addr[1:0] != 2'b00) begin
                            halt  <= 1'b1;
                            state <= ST_HALT;
                        end else begin
                            mem_addr  <= data_addr;
                            mem_we    <= is_store;
                            mem_wdata <= reg2_data;
                            state     <= ST_MEM;
                        end
                    end else if (is_branch) begin
                        pc       <= branch_target;
                        mem_addr <= branch_target;
                        retired  <= retired + 32'd1;
                        state    <= ST_FETCH;
                    end else if (is_jal || is_jalr) begin
                        // Jumps redirect pc here; the link uses the pre-jump pc.
                        pc             <= is_jal ? pc_offset : jalr_target;
                        reg_write_data <= pc_plus4;
                        reg_write_en   <= 1'b1;
                        state          <= ST_WRITEBACK;
                    end else begin
                        reg_write_data <= alu_result;
                        reg_write_en   <= 1'b1;
                        state          <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (is_store) begin
                            pc       <= pc_plus4;
                            mem_addr <= pc_plus4;
                            retired  <= retired + 32'd1;
                            state    <= ST_FETCH;
                        end else begin
                            reg_write_data <= mem_rdata;
                            reg_write_en   <= 1'b1;
                            state          <= ST_WRITEBACK;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    pc       <= wb_pc;
                    mem_addr <= wb_pc;
                    retired  <= retired + 32'd1;
                    state    <= ST_FETCH;
                end
                ST_HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    halt  <= 1'b1;
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_core_sequencer.sv
// Directed bench for rv_core_sequencer: bench-side memory responder plus scoreboards
// for register writebacks and data-memory requests.
module tb_rv_core_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] reg1_data;
    logic [31:0] reg2_data;
    logic [31:0] alu_result;
    logic        alu_branch;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] immediate;
    logic        alu_source;
    logic        reg_write_en;
    logic [31:0] reg_write_data;
    logic [31:0] pc;
    logic        halt;
    logic [31:0] retired;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } dm_t;

    wb_t wb_q[$];
    dm_t dm_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    rv_core_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .reg1_data(reg1_data),
        .reg2_data(reg2_data),
        .alu_result(alu_result),
        .alu_branch(alu_branch),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .opcode(opcode),
        .funct3(funct3),
        .funct7(funct7),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .immediate(immediate),
        .alu_source(alu_source),
        .reg_write_en(reg_write_en),
        .reg_write_data(reg_write_data),
        .pc(pc),
        .halt(halt),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one instruction from fetch to retirement (or halt). Called just after a
    // falling edge. abort_at >= 0 asserts rst once that many data wait cycles elapsed.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] alu_res,
                             input logic br, input int data_wait, input logic [31:0] rdata,
                             input int abort_at, output int cycles);
        logic        fetched;
        int          waits;
        bit          done;
        logic [31:0] start_ret;
        wb_t         w;
        dm_t         d;
        fetched    = 1'b0;
        waits      = 0;
        done       = 1'b0;
        cycles     = 0;
        start_ret  = exp_ret;
        reg1_data  = r1;
        reg2_data  = r2;
        alu_result = alu_res;
        alu_branch = br;
        enable     = 1'b1;
        #1;
        for (int n = 0; n < 40 && !done; n++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!fetched) begin
                    check("fetch_addr", mem_addr, exp_pc);
                    check("fetch_we", 32'(mem_we), 32'd0);
                    mem_ack   = 1'b1;
                    mem_rdata = instr;
                    fetched   = 1'b1;
                end else if (waits == abort_at) begin
                    rst = 1'b0;
                    #1;
                    check("rst_mem_req", 32'(mem_req), 32'd0);
                    check("rst_wr_en", 32'(reg_write_en), 32'd0);
                    check("rst_pc", pc, RESET_PC);
                    check("rst_retired", retired, 32'd0);
                    enable = 1'b0;
                    cycles = -1;
                    return;
                end else if (waits < data_wait) begin
                    waits++;
                end else begin
                    check("data_req_pending", 32'(dm_q.size() != 0), 32'd1);
                    if (dm_q.size() != 0) begin
                        d = dm_q.pop_front();
                        check("data_addr", mem_addr, d.addr);
                        check("data_we", 32'(mem_we), 32'(d.we));
                        if (d.we) check("data_wdata", mem_wdata, d.wdata);
                    end
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (reg_write_en) begin
                check("wb_pending", 32'(wb_q.size() != 0), 32'd1);
                if (wb_q.size() != 0) begin
                    w = wb_q.pop_front();
                    check("wb_rd", 32'(rd), 32'(w.rd));
                    check("wb_data", reg_write_data, w.data);
                end
            end
            @(posedge clk);
            if (fetched) cycles++;
            #1;
            mem_ack = 1'b0;
            @(negedge clk);
            #1;
            if (fetched) enable = 1'b0;
            done = (retired !== start_ret) || (halt === 1'b1);
        end
        mem_ack = 1'b0;
        enable  = 1'b0;
        check("instr_completes", 32'(done), 32'd1);
    endtask

    task automatic finish_instr(input string tag, input int cycles, input int exp_cycles,
                                input logic [31:0] next_pc, input bit retires);
        exp_pc = next_pc;
        if (retires) exp_ret = exp_ret + 32'd1;
        check({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_retired"}, retired, exp_ret);
        check({tag, "_wb_left"}, 32'(wb_q.size()), 32'd0);
        check({tag, "_dm_left"}, 32'(dm_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        enable  = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_pc  = RESET_PC;
        exp_ret = '0;
        wb_q.delete();
        dm_q.delete();
        check("reset_pc", pc, RESET_PC);
        check("reset_retired", retired, 32'd0);
        check("reset_halt", 32'(halt), 32'd0);
    endtask

    task automatic idle_requests(input int n, output int reqs);
        reqs   = 0;
        enable = 1'b1;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (mem_req) reqs++;
        end
        enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int reqs;
        rst        = 1'b0;
        enable     = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        reg1_data  = '0;
        reg2_data  = '0;
        alu_result = '0;
        alu_branch = 1'b0;
        exp_pc     = RESET_PC;
        exp_ret    = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_state_mem_req", 32'(mem_req), 32'd0);
        check("rst_state_wr_en", 32'(reg_write_en), 32'd0);
        check("rst_state_pc", pc, RESET_PC);
        check("rst_state_retired", retired, 32'd0);
        check("rst_state_halt", 32'(halt), 32'd0);
        check("rst_state_imm", immediate, 32'd0);
        check("rst_state_addr", mem_addr, RESET_PC);

        @(negedge clk);
        rst = 1'b1;
        idle_requests(0, reqs);
        repeat (3) @(negedge clk);
        #1;
        check("idle_no_req", 32'(mem_req), 32'd0);
        check("idle_pc", pc, RESET_PC);

        // addi x1,x0,5
        wb_q.push_back('{rd: 5'd1, data: 32'd5});
        run_instr(32'h00500093, 32'd0, 32'd0, 32'd5, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("addi", cyc, 4, 32'h4, 1'b1);
        check("addi_alu_src", 32'(alu_source), 32'd1);
        check("addi_imm", immediate, 32'd5);
        check("addi_opcode", 32'(opcode), 32'h13);

        // lw x2,8(x2) with three wait states on the data access
        dm_q.push_back('{addr: 32'h0000000C, we: 1'b0, wdata: 32'd0});
        wb_q.push_back('{rd: 5'd2, data: 32'hDEADBEEF});
        run_instr(32'h00812103, 32'd4, 32'd0, 32'd0, 1'b0, 3, 32'hDEADBEEF, -1, cyc);
        finish_instr("lw", cyc, 8, 32'h8, 1'b1);
        check("lw_funct3", 32'(funct3), 32'd2);
        check("lw_imm", immediate, 32'd8);

        // sw x3,4(x2)
        dm_q.push_back('{addr: 32'h00000104, we: 1'b1, wdata: 32'hCAFEF00D});
        run_instr(32'h00312223, 32'h100, 32'hCAFEF00D, 32'd0, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("sw", cyc, 4, 32'hC, 1'b1);
        check("sw_imm", immediate, 32'd4);
        check("sw_rs2", 32'(rs2), 32'd3);
        check("sw_mem_we_after", 32'(mem_we), 32'd0);

        // lui x5,0x12345
        wb_q.push_back('{rd: 5'd5, data: 32'h12345000});
        run_instr(32'h123452B7, 32'd0, 32'd0, 32'h12345000, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("lui", cyc, 4, 32'h10, 1'b1);
        check("lui_imm", immediate, 32'h00012345);
        check("lui_alu_src", 32'(alu_source), 32'd1);

        // beq +8, taken then not taken
        run_instr(32'h00000463, 32'd0, 32'd0, 32'd0, 1'b1, 0, 32'd0, -1, cyc);
        finish_instr("beq_t", cyc, 3, 32'h18, 1'b1);
        check("beq_imm", immediate, 32'd8);
        check("beq_alu_src", 32'(alu_source), 32'd0);
        run_instr(32'h00000463, 32'd0, 32'd0, 32'd0, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("beq_nt", cyc, 3, 32'h1C, 1'b1);

        // sub x6,x1,x2
        wb_q.push_back('{rd: 5'd6, data: 32'h11});
        run_instr(32'h40208333, 32'd0, 32'd0, 32'h11, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("sub", cyc, 4, 32'h20, 1'b1);
        check("sub_funct7", 32'(funct7), 32'h20);
        check("sub_imm", immediate, 32'd0);

        // jal x1,16
        wb_q.push_back('{rd: 5'd1, data: 32'h24});
        run_instr(32'h010000EF, 32'd0, 32'd0, 32'd0, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("jal", cyc, 4, 32'h30, 1'b1);
        check("jal_imm", immediate, 32'd16);

        // jalr x3,0(x4) with an odd base address
        wb_q.push_back('{rd: 5'd3, data: 32'h34});
        run_instr(32'h000201E7, 32'h101, 32'd0, 32'd0, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("jalr", cyc, 4, 32'h100, 1'b1);

        // bne -8, taken
        run_instr(32'hFE001CE3, 32'd0, 32'd0, 32'd0, 1'b1, 0, 32'd0, -1, cyc);
        finish_instr("bne_back", cyc, 3, 32'hF8, 1'b1);
        check("bne_imm", immediate, 32'hFFFFFFF8);

        // Illegal all-zero instruction halts
        run_instr(32'h00000000, 32'd0, 32'd0, 32'd0, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("illegal", cyc, 2, 32'hF8, 1'b0);
        check("illegal_halt", 32'(halt), 32'd1);
        idle_requests(6, reqs);
        check("halt_no_req", 32'(reqs), 32'd0);
        check("halt_pc_frozen", pc, 32'hF8);
        check("halt_retired_frozen", retired, exp_ret);

        // Misaligned load halts without a data request
        do_reset();
        run_instr(32'h00812103, 32'd1, 32'd0, 32'd0, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("lw_misalign", cyc, 3, RESET_PC, 1'b0);
        check("misalign_halt", 32'(halt), 32'd1);
        idle_requests(4, reqs);
        check("misalign_no_req", 32'(reqs), 32'd0);

        // Reset during a stalled load
        do_reset();
        wb_q.push_back('{rd: 5'd1, data: 32'd5});
        run_instr(32'h00500093, 32'd0, 32'd0, 32'd5, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("addi2", cyc, 4, 32'h4, 1'b1);
        run_instr(32'h00812103, 32'd4, 32'd0, 32'd0, 1'b0, 10, 32'd0, 2, cyc);
        check("abort_taken", 32'(cyc), 32'hFFFFFFFF);
        exp_pc  = RESET_PC;
        exp_ret = '0;
        wb_q.delete();
        dm_q.delete();
        repeat (2) @(negedge clk);
        enable = 1'b1;
        rst    = 1'b1;
        #1;
        check("restart_mem_req", 32'(mem_req), 32'd1);
        check("restart_addr", mem_addr, RESET_PC);
        check("restart_retired", retired, 32'd0);
        wb_q.push_back('{rd: 5'd1, data: 32'd5});
        run_instr(32'h00500093, 32'd0, 32'd0, 32'd5, 1'b0, 0, 32'd0, -1, cyc);
        finish_instr("addi3", cyc, 4, 32'h4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
